// File: rtl/conv2_window_gen.sv
// 3x3x3 sliding-window generator for a raster-order IMG_W x IMG_W, 3-channel feature map.
// Optional frame counter output is enabled by defining CONV2_WIN_FRAME_CNT_EN.
module conv2_window_gen #(
    parameter int IMG_W = 13,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3*DW-1:0]   data_in,
    input  logic              data_in_valid,
    output logic [27*DW-1:0]  win_out,
    output logic              win_valid,
    output logic              frame_done
`ifdef CONV2_WIN_FRAME_CNT_EN
    ,
    output logic [7:0]        frame_cnt
`endif
);

    localparam int PW = 3 * DW;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [CW-1:0]    col_q, col_d, row_q, row_d;
    logic [0:0]       state_q, state_d;
    logic             last_col, last_row, win_vld_d, done_d;
    logic [27*DW-1:0] win_d;

    // lb1 holds the row above the current one, lb2 the row two above
    logic [PW-1:0] lb1_q [IMG_W];
    logic [PW-1:0] lb2_q [IMG_W];
    // two previous columns of the window; the third column is formed from the incoming pixel
    logic [PW-1:0] sw_q  [3][2];
    logic [PW-1:0] sw_d  [3][2];
    logic [PW-1:0] col_new [3];

    always_comb begin
        last_col   = (col_q == CW'(IMG_W - 1));
        last_row   = (row_q == CW'(IMG_W - 1));
        col_new[0] = lb2_q[col_q];
        col_new[1] = lb1_q[col_q];
        col_new[2] = data_in;

        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        if (data_in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        case (state_q)
            FILL:    if (data_in_valid && last_col && row_q == CW'(1)) state_d = STREAM;
            STREAM:  if (data_in_valid && last_col && last_row)        state_d = FILL;
            default: state_d = FILL;
        endcase

        win_vld_d = data_in_valid && (state_q == STREAM) && (col_q >= CW'(2));
        done_d    = win_vld_d && last_col && last_row;

        win_d = win_out;
        for (int r = 0; r < 3; r++) begin
            sw_d[r][0] = sw_q[r][1];
            sw_d[r][1] = col_new[r];
            if (win_vld_d) begin
                win_d[(r*3+0)*PW +: PW] = sw_q[r][0];
                win_d[(r*3+1)*PW +: PW] = sw_q[r][1];
                win_d[(r*3+2)*PW +: PW] = col_new[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            state_q    <= FILL;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_out    <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            state_q    <= state_d;
            win_valid  <= win_vld_d;
            frame_done <= done_d;
            win_out    <= win_d;
        end
    end

    // Storage only; stale data is never exposed because windows need rows >= 2 of this frame
    always_ff @(posedge clk) begin
        if (data_in_valid) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= data_in;
            sw_q         <= sw_d;
        end
    end

`ifdef CONV2_WIN_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)       frame_cnt_q <= '0;
        else if (done_d) frame_cnt_q <= frame_cnt_q + 8'd1;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/conv2_window_gen.md
CONV2_WINDOW_GEN -- requirements
Module: conv2_window_gen

Interface
REQ-001 SHALL use clock clk; reset rst_n, asynchronous, active-high.
REQ-002 Parameter IMG_W, default 13, input feature-map width and height in pixels.
REQ-003 Parameter DW, default 32, bits per channel sample.
REQ-004 Ports, in order:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-high reset.
- data_in  input  3*DW  one pixel from pool1; channel k at bits [(k+1)*DW-1 : k*DW].
- data_in_valid  input  1  data_in accepted this cycle.
- win_out  output  27*DW  3x3x3 window, registered.
- win_valid  output  1  win_out holds a new window, one-cycle pulse.
- frame_done  output  1  one-cycle pulse with the last window of a frame.

Function
REQ-005 SHALL accept pixels in raster order, IMG_W x IMG_W per frame; no backpressure, and data_in_valid may deassert for any number of cycles.
REQ-006 SHALL keep col_cnt and row_cnt, 0..IMG_W-1, advancing only on accepted pixels: col wraps IMG_W-1 -> 0 and increments row; at (IMG_W-1, IMG_W-1) both return to 0.
REQ-007 SHALL hold two line buffers per channel, depth IMG_W, giving the pixels one and two rows above the current column; a buffer is written only on an accepted pixel.
REQ-008 SHALL keep a 3x3 shift window per channel that shifts left by one column on each accepted pixel; the new column is (row-2, row-1, current).
REQ-009 Window element (r,c), r=0 oldest row, c=0 leftmost, channel k, SHALL be placed at win_out bits starting at ((r*3+c)*3+k)*DW.
REQ-010 SHALL run a 2-state FSM:
- FILL: row_cnt < 2.
- STREAM: row_cnt >= 2.
- FILL -> STREAM on the accepted pixel that sets row_cnt = 2.
- STREAM -> FILL on the accepted pixel at (IMG_W-1, IMG_W-1).
REQ-011 SHALL pulse win_valid exactly 1 cycle after an accepted pixel with row_cnt >= 2 and col_cnt >= 2: (IMG_W-2)^2 = 121 windows per frame at default.
REQ-012 SHALL pulse frame_done in the same cycle as win_valid for pixel (IMG_W-1, IMG_W-1).
REQ-013 win_out SHALL hold its value between win_valid pulses.
REQ-014 Line buffers SHALL NOT be cleared between frames; stale contents never reach a window marked valid.
REQ-015 Back-to-back frames with no idle cycle SHALL work, and pixel (0,0) of frame n+1 may arrive the cycle after (IMG_W-1, IMG_W-1).
REQ-016 Arithmetic: no computation on data; samples pass through bit-exact.

Reset
REQ-017 On rst_n high the block SHALL asynchronously clear col_cnt, row_cnt, FSM (to FILL), win_valid, frame_done and win_out.
REQ-018 Reset mid-frame SHALL discard the partial frame; the first accepted pixel after release is (0,0).
REQ-019 Line-buffer storage need not be reset.

Configuration
REQ-020 Macro CONV2_WIN_FRAME_CNT_EN:
- When defined, adds output frame_cnt (8 bits), reset 0, incremented on each frame_done and wrapping 255 -> 0.
- When undefined, the port and its logic are absent and all other behaviour is identical.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Continuous frame, pixel value = row*16+col on all 3 channels -> 121 win_valid pulses; first window (r,c) = r*16+c; frame_done on the 121st pulse only.
- Same frame with valid gaps (1 pixel every 3 cycles) -> identical window sequence; each win_valid exactly 1 cycle after its pixel.
- Distinct channels (ch0 = v, ch1 = v+0x100, ch2 = v+0x200) -> packing per REQ-009 on every window.
- Two back-to-back frames (second frame offset by 0x1000) -> 242 windows; no second-frame window contains first-frame data.
- rst_n pulse after 50 pixels, then a full frame -> no win_valid during reset; exactly 121 correct windows afterwards.
- With CONV2_WIN_FRAME_CNT_EN, 3 frames -> frame_cnt = 1, 2, 3 after each frame_done.
